accum_dump: RTL and testbench

Parametrised integrate-and-dump accumulator for per-sample power/magnitude statistics in the E1x0 receive datapath. It sums a stream of qualified samples with saturating arithmetic and counts accepted samples. Every `len` samples it emits the window sum, sample count and an overflow flag, then restarts. With `len = 0` it runs as a free-running saturating accumulator that never dumps, which serves the existing software readback path.

---
 rtl/accum_pkg.sv | 25 ++
 rtl/accum_dump_sat_add.sv | 38 +++
 rtl/accum_dump.sv | 106 ++++++++++
 tb/tb_accum_dump.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/accum_pkg.sv
// Shared types and constants for the integrate-and-dump accumulator family.
// Rail values are produced at 64 bits and sliced to the accumulator width by the user.
package accum_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WIN  = 2'd1,
      FREE = 2'd2
   } state_t;

   localparam int SIGNED_OFF = 0;
   localparam int SIGNED_ON  = 1;

   function automatic logic [63:0] rail_hi(input int w, input int sgn);
      if (sgn == SIGNED_ON) return (64'd1 << (w - 1)) - 64'd1;
      else if (w >= 64) return '1;
      else return (64'd1 << w) - 64'd1;
   endfunction

   function automatic logic [63:0] rail_lo(input int w, input int sgn);
      if (sgn == SIGNED_ON) return 64'd1 << (w - 1);
      else return 64'd0;
   endfunction

endpackage

// File: rtl/accum_dump_sat_add.sv
// Combinational saturating adder: one ACC_WIDTH+1 bit add followed by a clamp mux.
module sat_add
   import accum_pkg::*;
#(
   parameter int ACC_WIDTH = 32,
   parameter int SIGNED    = 0
) (
   input  logic [ACC_WIDTH-1:0] a,
   input  logic [ACC_WIDTH-1:0] b_ext,
   output logic [ACC_WIDTH-1:0] sum,
   output logic                 clamped
);

   localparam logic [63:0] HI64 = rail_hi(ACC_WIDTH, SIGNED);
   localparam logic [63:0] LO64 = rail_lo(ACC_WIDTH, SIGNED);
   localparam logic [ACC_WIDTH-1:0] HI = HI64[ACC_WIDTH-1:0];
   localparam logic [ACC_WIDTH-1:0] LO = LO64[ACC_WIDTH-1:0];

   logic [ACC_WIDTH:0] wide;

   always_comb begin
      if (SIGNED == SIGNED_ON) wide = {a[ACC_WIDTH-1], a} + {b_ext[ACC_WIDTH-1], b_ext};
      else wide = {1'b0, a} + {1'b0, b_ext};
      sum     = wide[ACC_WIDTH-1:0];
      clamped = 1'b0;
      if (SIGNED == SIGNED_ON) begin
         // The two top bits disagree only on overflow; the extra bit carries the true sign.
         if (wide[ACC_WIDTH] != wide[ACC_WIDTH-1]) begin
            clamped = 1'b1;
            sum     = wide[ACC_WIDTH] ? LO : HI;
         end
      end else if (wide[ACC_WIDTH]) begin
         clamped = 1'b1;
         sum     = HI;
      end
   end

endmodule

// File: rtl/accum_dump.sv
// Integrate-and-dump accumulator: saturating window sum with per-window dump,
// or a free-running accumulator when the latched length is zero.
module accum_dump
   import accum_pkg::*;
#(
   parameter int IN_WIDTH  = 16,
   parameter int ACC_WIDTH = 32,
   parameter int CNT_WIDTH = 10,
   parameter int SIGNED    = 0
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 clear,
   input  logic                 in_valid,
   input  logic [IN_WIDTH-1:0]  in_data,
   input  logic [CNT_WIDTH-1:0] len,
   output logic [ACC_WIDTH-1:0] accum,
   output logic [CNT_WIDTH-1:0] counter,
   output logic                 out_valid,
   output logic [ACC_WIDTH-1:0] out_sum,
   output logic [CNT_WIDTH-1:0] out_count,
   output logic                 out_sat,
   output logic                 sat
);

   state_t                 state, state_next;
   logic [CNT_WIDTH-1:0]   len_q, len_eff, cnt_next;
   logic [ACC_WIDTH-1:0]   b_ext, sum;
   logic                   clamped, accept, dump;

   always_comb begin
      if (SIGNED == SIGNED_ON) b_ext = ACC_WIDTH'($signed(in_data));
      else b_ext = ACC_WIDTH'(in_data);
   end

   sat_add #(
      .ACC_WIDTH (ACC_WIDTH),
      .SIGNED    (SIGNED)
   ) u_sat_add (
      .a       (accum),
      .b_ext   (b_ext),
      .sum     (sum),
      .clamped (clamped)
   );

   // The first sample of a window sees the live len; later samples see the latched copy.
   assign accept   = in_valid && !clear;
   assign len_eff  = (state == IDLE) ? len : len_q;
   assign cnt_next = (&counter) ? counter : counter + 1'b1;
   assign dump     = accept && (state != FREE) && (cnt_next == len_eff);

   always_comb begin
      state_next = state;
      if (clear) begin
         state_next = IDLE;
      end else if (accept) begin
         case (state)
            IDLE:    state_next = dump ? IDLE : ((len == '0) ? FREE : WIN);
            WIN:     if (dump) state_next = IDLE;
            FREE:    state_next = FREE;
            default: state_next = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else state <= state_next;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         accum     <= '0;
         counter   <= '0;
         sat       <= 1'b0;
         len_q     <= '0;
         out_valid <= 1'b0;
         out_sum   <= '0;
         out_count <= '0;
         out_sat   <= 1'b0;
      end else begin
         out_valid <= 1'b0;
         if (clear) begin
            accum   <= '0;
            counter <= '0;
            sat     <= 1'b0;
         end else if (accept) begin
            if (state == IDLE) len_q <= len;
            if (dump) begin
               out_sum   <= sum;
               out_count <= len_eff;
               out_sat   <= sat | clamped;
               out_valid <= 1'b1;
               accum     <= '0;
               counter   <= '0;
               sat       <= 1'b0;
            end else begin
               accum   <= sum;
               counter <= cnt_next;
               sat     <= sat | clamped;
            end
         end
      end
   end

endmodule

// File: tb/tb_accum_dump.sv
// Bench for accum_dump: an unsigned 16/17-bit instance and a signed 16/18-bit instance,
// each compared every cycle against an arithmetic window model.
module tb_accum_dump;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        u_reset, u_clear, u_valid, u_ovalid, u_osat, u_sat;
   logic [15:0] u_data;
   logic [3:0]  u_len, u_counter, u_ocount;
   logic [16:0] u_accum, u_osum;

   logic        s_reset, s_clear, s_valid, s_ovalid, s_osat, s_sat;
   logic [15:0] s_data;
   logic [9:0]  s_len, s_counter, s_ocount;
   logic [17:0] s_accum, s_osum;

   accum_dump #(.IN_WIDTH(16), .ACC_WIDTH(17), .CNT_WIDTH(4), .SIGNED(0)) u_dut (
      .clk(clk), .reset(u_reset), .clear(u_clear), .in_valid(u_valid), .in_data(u_data),
      .len(u_len), .accum(u_accum), .counter(u_counter), .out_valid(u_ovalid),
      .out_sum(u_osum), .out_count(u_ocount), .out_sat(u_osat), .sat(u_sat));

   accum_dump #(.IN_WIDTH(16), .ACC_WIDTH(18), .CNT_WIDTH(10), .SIGNED(1)) s_dut (
      .clk(clk), .reset(s_reset), .clear(s_clear), .in_valid(s_valid), .in_data(s_data),
      .len(s_len), .accum(s_accum), .counter(s_counter), .out_valid(s_ovalid),
      .out_sum(s_osum), .out_count(s_ocount), .out_sat(s_osat), .sat(s_sat));

   typedef struct {
      longint acc;
      int     cnt;
      int     lenq;
      bit     run;
      bit     free;
      bit     sat;
      bit     ov;
      longint osum;
      int     ocnt;
      bit     osat;
   } mdl_t;

   mdl_t mu, ms;
   int   total = 0;
   int   bad   = 0;

   // Window behaviour computed from plain integer arithmetic with clamping to the rails.
   function automatic mdl_t mstep(input mdl_t m, input bit rst, input bit clr, input bit v,
                                  input longint x, input int ln, input int aw, input bit sg,
                                  input int cw);
      mdl_t   n;
      longint hi, lo, s;
      bit     c;
      int     cmax;
      n = m;
      n.ov = 1'b0;
      if (rst) begin
         n = '{default: 0};
         return n;
      end
      if (clr) begin
         n.acc = 0; n.cnt = 0; n.sat = 0; n.run = 0; n.free = 0;
         return n;
      end
      if (!v) return n;
      if (!m.run) begin
         n.run = 1; n.lenq = ln; n.free = (ln == 0);
      end
      hi = sg ? (longint'(1) << (aw - 1)) - 1 : (longint'(1) << aw) - 1;
      lo = sg ? -(longint'(1) << (aw - 1)) : 0;
      cmax = (1 << cw) - 1;
      s = m.acc + x;
      c = 0;
      if (s > hi) begin s = hi; c = 1; end
      if (s < lo) begin s = lo; c = 1; end
      n.cnt = (m.cnt + 1 > cmax) ? cmax : m.cnt + 1;
      if (!n.free && n.cnt == n.lenq) begin
         n.osum = s; n.ocnt = n.lenq; n.osat = m.sat | c; n.ov = 1;
         n.acc = 0; n.cnt = 0; n.sat = 0; n.run = 0;
      end else begin
         n.acc = s;
         n.sat = m.sat | c;
      end
      return n;
   endfunction

   task automatic chk(input string tag, input longint got, input longint exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic u_in(input bit r, input bit c, input bit v, input logic [15:0] d,
                       input logic [3:0] l);
      u_reset = r; u_clear = c; u_valid = v; u_data = d; u_len = l;
   endtask

   task automatic s_in(input bit r, input bit c, input bit v, input logic [15:0] d,
                       input logic [9:0] l);
      s_reset = r; s_clear = c; s_valid = v; s_data = d; s_len = l;
   endtask

   task automatic tick();
      mu = mstep(mu, u_reset, u_clear, u_valid, longint'(u_data), int'(u_len), 17, 1'b0, 4);
      ms = mstep(ms, s_reset, s_clear, s_valid, longint'($signed(s_data)), int'(s_len), 18, 1'b1, 10);
      @(posedge clk);
      #1;
      chk("u_accum", u_accum, mu.acc);
      chk("u_counter", u_counter, mu.cnt);
      chk("u_sat", u_sat, mu.sat);
      chk("u_out_valid", u_ovalid, mu.ov);
      chk("u_out_sum", u_osum, mu.osum);
      chk("u_out_count", u_ocount, mu.ocnt);
      chk("u_out_sat", u_osat, mu.osat);
      chk("s_accum", longint'($signed(s_accum)), ms.acc);
      chk("s_counter", s_counter, ms.cnt);
      chk("s_sat", s_sat, ms.sat);
      chk("s_out_valid", s_ovalid, ms.ov);
      chk("s_out_sum", longint'($signed(s_osum)), ms.osum);
      chk("s_out_count", s_ocount, ms.ocnt);
      chk("s_out_sat", s_osat, ms.osat);
   endtask

   initial begin
      mu = '{default: 0};
      ms = '{default: 0};
      u_in(1, 0, 0, 16'd0, 4'd0);
      s_in(1, 0, 0, 16'd0, 10'd0);
      tick();
      chk("rst_accum", u_accum, 0);
      chk("rst_out_valid", u_ovalid, 0);
      chk("rst_out_sum", u_osum, 0);
      s_in(0, 0, 0, 16'd0, 10'd0);

      // Basic window of four, then a sample on the dump cycle.
      u_in(0, 0, 1, 16'd1, 4'd4); tick();
      u_in(0, 0, 1, 16'd2, 4'd4); tick();
      u_in(0, 0, 1, 16'd3, 4'd4); tick();
      u_in(0, 0, 1, 16'd4, 4'd4); tick();
      chk("t1_out_valid", u_ovalid, 1);
      chk("t1_out_sum", u_osum, 10);
      chk("t1_out_count", u_ocount, 4);
      chk("t1_out_sat", u_osat, 0);
      u_in(0, 0, 1, 16'd5, 4'd4); tick();
      chk("t1_next_accum", u_accum, 5);
      chk("t1_next_counter", u_counter, 1);
      u_in(0, 1, 0, 16'd0, 4'd0); tick();

      // Unsigned saturation at 17 bits.
      for (int i = 0; i < 3; i++) begin
         u_in(0, 0, 1, 16'hFFFF, 4'd3); tick();
      end
      chk("t2_out_sum", u_osum, 17'h1FFFF);
      chk("t2_out_sat", u_osat, 1);
      u_in(0, 0, 1, 16'd1, 4'd3); tick();
      chk("t2_new_sat", u_sat, 0);
      u_in(0, 1, 0, 16'd0, 4'd0); tick();

      // Length change mid-window is ignored until the next window.
      u_in(0, 0, 1, 16'd1, 4'd4); tick();
      for (int i = 0; i < 3; i++) begin
         u_in(0, 0, 1, 16'd1, 4'd2); tick();
      end
      chk("t4_out_count", u_ocount, 4);
      u_in(0, 0, 1, 16'd3, 4'd2); tick();
      u_in(0, 0, 1, 16'd3, 4'd2); tick();
      chk("t4_out_count2", u_ocount, 2);
      chk("t4_out_valid2", u_ovalid, 1);

      // Clear drops the coincident sample and leaves the hold registers alone.
      u_in(0, 0, 1, 16'd1, 4'd4); tick();
      u_in(0, 0, 1, 16'd1, 4'd4); tick();
      u_in(0, 1, 1, 16'd1, 4'd4); tick();
      chk("t5_accum", u_accum, 0);
      chk("t5_counter", u_counter, 0);
      chk("t5_out_sum_held", u_osum, 6);
      for (int i = 0; i < 4; i++) begin
         u_in(0, 0, 1, 16'd1, 4'd4); tick();
      end
      chk("t5_out_sum", u_osum, 4);

      // Reset on the last sample of a window suppresses the dump.
      u_in(0, 0, 1, 16'd7, 4'd2); tick();
      u_in(1, 0, 1, 16'd7, 4'd2); tick();
      chk("t6_out_valid", u_ovalid, 0);
      chk("t6_out_sum", u_osum, 0);
      u_in(0, 0, 0, 16'd0, 4'd0); tick();
      chk("t6_out_valid_late", u_ovalid, 0);

      // Free run: counter sticks at all-ones.
      for (int i = 0; i < 18; i++) begin
         u_in(0, 0, 1, 16'd1, 4'd0); tick();
      end
      chk("free_counter", u_counter, 15);
      chk("free_accum", u_accum, 18);
      u_in(0, 1, 0, 16'd0, 4'd0); tick();
      u_in(0, 0, 0, 16'd0, 4'd0);

      // Signed negative rail, then recovery off the rail.
      for (int i = 0; i < 5; i++) begin
         s_in(0, 0, 1, 16'h8000, 10'd0); tick();
      end
      chk("sg_accum_min", longint'($signed(s_accum)), -131072);
      chk("sg_sat", s_sat, 1);
      s_in(0, 0, 1, 16'h7FFF, 10'd0); tick();
      chk("sg_accum_back", longint'($signed(s_accum)), -98305);
      chk("sg_out_valid", s_ovalid, 0);
      s_in(0, 1, 0, 16'd0, 10'd0); tick();

      // Randomized traffic on both instances.
      for (int i = 0; i < 400; i++) begin
         u_in(($urandom_range(0, 99) == 0), ($urandom_range(0, 19) == 0),
              ($urandom_range(0, 9) < 7),
              ($urandom_range(0, 1) == 1) ? 16'($urandom_range(16'hC000, 16'hFFFF))
                                          : 16'($urandom_range(0, 255)),
              4'($urandom_range(0, 5)));
         s_in(($urandom_range(0, 99) == 0), ($urandom_range(0, 19) == 0),
              ($urandom_range(0, 9) < 7), 16'($urandom), 10'($urandom_range(0, 5)));
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
